hilo_muldiv: RTL and testbench

Parametrised successor to the HI/LO register pair. Holds the HI and LO special registers and adds an iterative multiply/divide engine (signed/unsigned MULT and DIV) plus single-cycle MTHI/MTLO writes. Multi-cycle results commit atomically to HI/LO. It sits beside the EX stage, which stalls on `busy` and reads HI/LO for MFHI/MFLO.

---
 rtl/hilo_muldiv.sv | 155 +++++++++++++++
 tb/tb_hilo_muldiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO special-register pair with an iterative radix-2 multiply/divide engine.
// Mul/div results commit to HI/LO atomically in the FIX cycle; MTHI/MTLO write in one edge.
module hilo_muldiv #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         op_valid,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi_rdata,
  output logic [W-1:0] lo_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [W-1:0]     hi_q, lo_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     acc_hi, acc_lo;
  logic [W-1:0]     addend;
  logic [W-1:0]     a_raw;
  logic             is_div, neg_q, neg_r, div_zero;

  logic             accept, start_md, wr_hi, wr_lo, step, commit;
  logic             signed_in, a_neg_in, b_neg_in;
  logic [W-1:0]     a_mag_in, b_mag_in;
  logic [W:0]       mul_sum, div_trial;
  logic             div_ok;
  logic [2*W-1:0]   product, product_fix;
  logic [W-1:0]     quo_fix, rem_fix;

  // Operand magnitudes and sign flags; MULTU/DIVU have op_code[0] set.
  assign signed_in = ~op_code[0];
  assign a_neg_in  = signed_in & src_a[W-1];
  assign b_neg_in  = signed_in & src_b[W-1];
  assign a_mag_in  = a_neg_in ? (~src_a + 1'b1) : src_a;
  assign b_mag_in  = b_neg_in ? (~src_b + 1'b1) : src_b;

  assign accept   = (state == IDLE) && op_valid && !cancel;
  assign start_md = accept && !op_code[2];
  assign wr_hi    = accept && (op_code == 3'd4);
  assign wr_lo    = accept && (op_code == 3'd5);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: if (start_md) next_state = RUN;
      RUN: begin
        if (cancel) begin
          next_state = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(W - 1)) next_state = FIX;
        end
      end
      FIX: begin
        next_state = IDLE;
        commit     = !cancel;
      end
      default: next_state = IDLE;
    endcase
  end

  // acc_hi holds the running partial product / partial remainder; acc_lo the
  // multiplier bits still to consume / the dividend bits shifting into quotient.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : {(W+1){1'b0}});
  assign div_trial = {acc_hi, acc_lo[W-1]} - {1'b0, addend};
  assign div_ok    = ~div_trial[W];

  assign product     = {acc_hi, acc_lo};
  assign product_fix = neg_q ? (~product + 1'b1) : product;
  assign quo_fix     = neg_q ? (~acc_lo + 1'b1) : acc_lo;
  assign rem_fix     = neg_r ? (~acc_hi + 1'b1) : acc_hi;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      addend   <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_q <= commit;
      if (wr_hi) hi_q <= src_a;
      if (wr_lo) lo_q <= src_a;

      if (start_md) begin
        is_div   <= op_code[1];
        addend   <= op_code[1] ? b_mag_in : a_mag_in;
        acc_hi   <= '0;
        acc_lo   <= op_code[1] ? a_mag_in : b_mag_in;
        neg_q    <= a_neg_in ^ b_neg_in;
        neg_r    <= a_neg_in;
        div_zero <= op_code[1] && (src_b == '0);
        a_raw    <= src_a;
        cnt      <= '0;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
        if (is_div) begin
          if (div_ok) acc_hi <= div_trial[W-1:0];
          else        acc_hi <= {acc_hi[W-2:0], acc_lo[W-1]};
          acc_lo <= {acc_lo[W-2:0], div_ok};
        end else begin
          acc_hi <= mul_sum[W:1];
          acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
        end
      end

      if (commit) begin
        if (!is_div) begin
          hi_q <= product_fix[2*W-1:W];
          lo_q <= product_fix[W-1:0];
        end else if (div_zero) begin
          hi_q <= a_raw;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv (W=32): MTHI/MTLO, MULT/MULTU,
// DIV/DIVU incl. overflow and divide-by-zero, cancel, and asynchronous reset mid-run.
module tb_hilo_muldiv;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  int checks;
  int failures;

  hilo_muldiv #(.W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .op_valid (op_valid),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request for a single cycle, then count edges until done (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    op_valid = 1'b1;
    op_code  = op;
    src_a    = a;
    src_b    = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat      = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++; if (hi_rdata !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected %h", hi_rdata, 32'h0); end
    checks++; if (lo_rdata !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected %h", lo_rdata, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo();
    op_valid = 1'b1; op_code = 3'd4; src_a = 32'h12345678; src_b = 32'h0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (hi_rdata !== 32'h12345678) begin failures++; $display("FAIL mthi_hi: got %h expected %h", hi_rdata, 32'h12345678); end
    checks++; if (lo_rdata !== 32'h0) begin failures++; $display("FAIL mthi_lo: got %h expected %h", lo_rdata, 32'h0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", busy, done); end
    op_valid = 1'b1; op_code = 3'd5; src_a = 32'h9ABCDEF0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (lo_rdata !== 32'h9ABCDEF0) begin failures++; $display("FAIL mtlo_lo: got %h expected %h", lo_rdata, 32'h9ABCDEF0); end
    checks++; if (hi_rdata !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi: got %h expected %h", hi_rdata, 32'h12345678); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtlo_flags: got busy=%b done=%b expected 0 0", busy, done); end
    // op codes 6 and 7 leave both registers alone
    op_valid = 1'b1; op_code = 3'd6; src_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (hi_rdata !== 32'h12345678 || lo_rdata !== 32'h9ABCDEF0) begin failures++; $display("FAIL nop: got hi=%h lo=%h expected 12345678 9abcdef0", hi_rdata, lo_rdata); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(3'd0, 32'hFFFFFFFF, 32'd2, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL mult_latency: got %0d expected 33", lat); end
    checks++; if (bc !== 33) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_in_done: got %b expected 0", busy); end
    checks++; if (hi_rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected %h", hi_rdata, 32'hFFFFFFFF); end
    checks++; if (lo_rdata !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo: got %h expected %h", lo_rdata, 32'hFFFFFFFE); end
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    checks++; if (hi_rdata !== 32'h00000001) begin failures++; $display("FAIL multu_hi: got %h expected %h", hi_rdata, 32'h1); end
    checks++; if (lo_rdata !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo: got %h expected %h", lo_rdata, 32'hFFFFFFFE); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_mult_signed();
    int lat, bc;
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL mult_neg_latency: got %0d expected 33", lat); end
    checks++; if (hi_rdata !== 32'hFFFFFFFF || lo_rdata !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_neg: got hi=%h lo=%h expected ffffffff fffffff1", hi_rdata, lo_rdata); end
    run_op(3'd1, 32'h00012345, 32'h00010000, lat, bc);
    checks++; if (hi_rdata !== 32'h00000001 || lo_rdata !== 32'h23450000) begin failures++; $display("FAIL multu_shift: got hi=%h lo=%h expected 00000001 23450000", hi_rdata, lo_rdata); end
  endtask

  task automatic test_divide();
    int lat, bc;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency: got %0d expected 33", lat); end
    checks++; if (lo_rdata !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_quo: got %h expected %h", lo_rdata, 32'hFFFFFFFD); end
    checks++; if (hi_rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_rem: got %h expected %h", hi_rdata, 32'hFFFFFFFF); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    checks++; if (lo_rdata !== 32'h80000000 || hi_rdata !== 32'h0) begin failures++; $display("FAIL div_overflow: got hi=%h lo=%h expected 00000000 80000000", hi_rdata, lo_rdata); end
    run_op(3'd3, 32'd100, 32'd7, lat, bc);
    checks++; if (lo_rdata !== 32'd14 || hi_rdata !== 32'd2) begin failures++; $display("FAIL divu_basic: got hi=%h lo=%h expected 00000002 0000000e", hi_rdata, lo_rdata); end
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, lat, bc);
    checks++; if (lo_rdata !== 32'hFFFFFFFD || hi_rdata !== 32'd1) begin failures++; $display("FAIL div_pos_neg: got hi=%h lo=%h expected 00000001 fffffffd", hi_rdata, lo_rdata); end
    run_op(3'd3, 32'd100, 32'd0, lat, bc);
    checks++; if (lo_rdata !== 32'hFFFFFFFF || hi_rdata !== 32'd100) begin failures++; $display("FAIL divu_by_zero: got hi=%h lo=%h expected 00000064 ffffffff", hi_rdata, lo_rdata); end
    run_op(3'd2, 32'hFFFFFFFB, 32'd0, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_zero_latency: got %0d expected 33", lat); end
    checks++; if (lo_rdata !== 32'hFFFFFFFF || hi_rdata !== 32'hFFFFFFFB) begin failures++; $display("FAIL div_by_zero: got hi=%h lo=%h expected fffffffb ffffffff", hi_rdata, lo_rdata); end
  endtask

  task automatic test_cancel();
    int lat;
    logic saw_done;
    op_valid = 1'b1; op_code = 3'd4; src_a = 32'hAA;
    @(posedge clk); #1;
    op_code = 3'd5;
    @(posedge clk); #1;
    op_valid = 1'b0;
    // cancel while idle suppresses an otherwise valid request
    op_valid = 1'b1; op_code = 3'd4; src_a = 32'h55; cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; cancel = 1'b0;
    checks++; if (hi_rdata !== 32'hAA) begin failures++; $display("FAIL idle_cancel_blocks: got %h expected %h", hi_rdata, 32'hAA); end
    op_valid = 1'b1; op_code = 3'd3; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    cancel = 1'b1; op_valid = 1'b1; op_code = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    checks++; if (saw_done !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL cancel_done: got %b expected 0", saw_done | done); end
    checks++; if (hi_rdata !== 32'hAA || lo_rdata !== 32'hAA) begin failures++; $display("FAIL cancel_hilo: got hi=%h lo=%h expected 000000aa 000000aa", hi_rdata, lo_rdata); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL accept_after_cancel: got busy=%b expected 1", busy); end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 33) begin failures++; $display("FAIL post_cancel_latency: got %0d expected 33", lat); end
    checks++; if (lo_rdata !== 32'd12 || hi_rdata !== 32'd0) begin failures++; $display("FAIL post_cancel_result: got hi=%h lo=%h expected 00000000 0000000c", hi_rdata, lo_rdata); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    op_valid = 1'b1; op_code = 3'd4; src_a = 32'h77;
    @(posedge clk); #1;
    op_valid = 1'b1; op_code = 3'd1; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
    end
    #2 resetn = 1'b0;
    #1;
    checks++; if (hi_rdata !== 32'h0 || lo_rdata !== 32'h0) begin failures++; $display("FAIL async_reset_hilo: got hi=%h lo=%h expected 0 0", hi_rdata, lo_rdata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(3'd1, 32'd3, 32'd5, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL post_reset_latency: got %0d expected 33", lat); end
    checks++; if (lo_rdata !== 32'd15 || hi_rdata !== 32'd0) begin failures++; $display("FAIL post_reset_result: got hi=%h lo=%h expected 00000000 0000000f", hi_rdata, lo_rdata); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    op_valid = 1'b0;
    op_code  = 3'd0;
    src_a    = 32'h0;
    src_b    = 32'h0;
    cancel   = 1'b0;
    resetn   = 1'b0;
    test_reset();
    test_mthi_mtlo();
    test_back_to_back();
    test_mult_signed();
    test_divide();
    test_cancel();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
